instr_fetch_unit: RTL and testbench

Fetch stage of the RV32I core. It sits directly upstream of decode and immediate extension. It holds the PC, runs a request/acknowledge handshake with instruction memory, and latches each fetched word into an instruction register. That register drives the decoder and the immediate extender's 32-bit instruction input. Downstream branch/jump logic returns a redirect target (pc + extended immediate) through the redirect port.

---
 rtl/instr_fetch_unit_if.sv | 10 +
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC, imem request/ack handshake and the instruction register
// feeding decode and immediate extension.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic [31:0]         instr,
  output logic [31:0]         instr_pc,
  output logic                instr_valid,
  output logic [31:0]         pc_plus4,
  output logic                misalign_err
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {BOOT, REQ, DROP, VALID} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_target;
  logic            req;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next;

  // Misaligned targets are still taken, with the low bits dropped.
  assign target   = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_next  = pc + XLEN'(4);
  assign pc_plus4 = instr_pc + XLEN'(4);

  // In DROP, pc keeps the abandoned address so the outstanding request stays stable.
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      pc_target    <= RESET_PC;
      req          <= 1'b0;
      instr        <= NOP_INSTR;
      instr_pc     <= RESET_PC;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
      unique case (state)
        BOOT: begin
          if (redirect) pc <= target;
          req   <= 1'b1;
          state <= REQ;
        end
        REQ: begin
          if (redirect) begin
            if (imem.imem_ack) begin
              pc <= target;
            end else begin
              pc_target <= target;
              state     <= DROP;
            end
          end else if (imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc_next;
            req         <= 1'b0;
            state       <= VALID;
          end
        end
        DROP: begin
          // Last redirect wins, including one landing on the ack cycle.
          if (imem.imem_ack) begin
            pc    <= redirect ? target : pc_target;
            state <= REQ;
          end else if (redirect) begin
            pc_target <= target;
          end
        end
        VALID: begin
          if (redirect || !stall) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            req         <= 1'b1;
            state       <= REQ;
          end
          if (redirect) pc <= target;
        end
        default: begin
          state <= BOOT;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch addresses and delivered
// instructions are queued by the stimulus and popped by independent monitors.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A: RESET_PC = 0
  logic        rst_n = 1'b0;
  logic        stall_a = 1'b0;
  logic        redirect_a = 1'b0;
  logic [31:0] redirect_pc_a = 32'h0;
  logic [31:0] instr_a, instr_pc_a, pc_plus4_a;
  logic        instr_valid_a, misalign_a;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  instr_fetch_unit_if ifa();
  assign ifa.imem_ack   = mem_ack;
  assign ifa.imem_rdata = mem_rdata;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut_a (
    .clk(clk), .rst_n(rst_n), .imem(ifa), .stall(stall_a), .redirect(redirect_a),
    .redirect_pc(redirect_pc_a), .instr(instr_a), .instr_pc(instr_pc_a),
    .instr_valid(instr_valid_a), .pc_plus4(pc_plus4_a), .misalign_err(misalign_a));

  // DUT B: RESET_PC at the top of the address space, zero-wait memory
  logic        rst_b = 1'b0;
  logic        stall_b = 1'b1;
  logic [31:0] instr_b, instr_pc_b, pc_plus4_b;
  logic        instr_valid_b, misalign_b;
  logic        mem_ack_b = 1'b0;
  instr_fetch_unit_if ifb();
  assign ifb.imem_ack   = mem_ack_b;
  assign ifb.imem_rdata = 32'h00A0_0113;

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_b (
    .clk(clk), .rst_n(rst_b), .imem(ifb), .stall(stall_b), .redirect(1'b0),
    .redirect_pc(32'h0), .instr(instr_b), .instr_pc(instr_pc_b),
    .instr_valid(instr_valid_b), .pc_plus4(pc_plus4_b), .misalign_err(misalign_b));

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          ack_delay = 1;
  logic        boot_ack = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h0050_0093 ^ {addr[26:0], 5'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic push_fetch(input logic [31:0] addr, input bit delivered);
    exp_t e;
    addr_q.push_back(addr);
    if (delivered) begin
      e.word = mem_word(addr);
      e.pc   = addr;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_valid_a(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!instr_valid_a && k < 40);
    if (!instr_valid_a) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: instr_valid 0 after %0d cycles, required 1", name, k);
    end
  endtask

  // Memory model for DUT A; checks each completed request against the expected address.
  int          wait_cnt = 0;
  logic [31:0] start_addr = 32'h0;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (boot_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      boot_ack  = 1'b0;
      wait_cnt  = 0;
    end else if (ifa.imem_req) begin
      if (wait_cnt == 0) start_addr = ifa.imem_addr;
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(ifa.imem_addr);
        wait_cnt  = 0;
        check("addr_stable", ifa.imem_addr, start_addr);
        if (addr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL imem_addr: unexpected request at 0x%08h, required none", ifa.imem_addr);
        end else begin
          check("imem_addr", ifa.imem_addr, addr_q.pop_front());
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always @(negedge clk) mem_ack_b = ifb.imem_req;

  // Scoreboard monitor: each newly presented instruction is compared with the queue head.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (instr_valid_a && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL instr: unexpected instruction 0x%08h, required none", instr_a);
      end else begin
        e = exp_q.pop_front();
        check("instr", instr_a, e.word);
        check("instr_pc", instr_pc_a, e.pc);
        check("pc_plus4", pc_plus4_a, e.pc + 32'd4);
      end
    end
    prev_valid = instr_valid_a;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_req", 32'(ifa.imem_req), 32'h0);
    check("rst_addr", ifa.imem_addr, 32'h0);
    check("rst_instr", instr_a, NOP);
    check("rst_instr_pc", instr_pc_a, 32'h0);
    check("rst_valid", 32'(instr_valid_a), 32'h0);
    check("rst_misalign", 32'(misalign_a), 32'h0);

    // 1: first fetch at 0, then 4
    push_fetch(32'h0, 1'b1);
    check("mem_word0", mem_word(32'h0), 32'h0050_0093);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid_a("fetch0");
    push_fetch(32'h4, 1'b1);

    // 2: stall holds the instruction and keeps imem_req low
    @(negedge clk);
    stall_a = 1'b1;
    wait_valid_a("fetch4");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(instr_valid_a), 32'h1);
      check("stall_instr", instr_a, mem_word(32'h4));
      check("stall_instr_pc", instr_pc_a, 32'h4);
      check("stall_req", 32'(ifa.imem_req), 32'h0);
    end
    push_fetch(32'h8, 1'b1);
    stall_a = 1'b0;
    @(negedge clk);
    check("unstall_req", 32'(ifa.imem_req), 32'h1);
    check("unstall_addr", ifa.imem_addr, 32'h8);
    wait_valid_a("fetch8");

    // 3: redirect during a slow request; old request completes, data dropped
    ack_delay = 3;
    @(negedge clk);
    redirect_a    = 1'b1;
    redirect_pc_a = 32'h100;
    push_fetch(32'hC, 1'b0);
    push_fetch(32'h100, 1'b1);
    @(negedge clk);
    redirect_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("drop_addr", ifa.imem_addr, 32'hC);
      check("drop_req", 32'(ifa.imem_req), 32'h1);
      check("drop_valid", 32'(instr_valid_a), 32'h0);
      @(negedge clk);
    end
    check("drop_misalign", 32'(misalign_a), 32'h0);
    wait_valid_a("fetch100");

    // 4: misaligned redirect while holding a valid instruction
    redirect_a    = 1'b1;
    redirect_pc_a = 32'h102;
    ack_delay     = 1;
    push_fetch(32'h100, 1'b1);
    @(negedge clk);
    redirect_a = 1'b0;
    check("mis_err", 32'(misalign_a), 32'h1);
    check("mis_valid", 32'(instr_valid_a), 32'h0);
    check("mis_instr", instr_a, NOP);
    check("mis_addr", ifa.imem_addr, 32'h100);
    @(negedge clk);
    check("mis_err_pulse", 32'(misalign_a), 32'h0);
    wait_valid_a("refetch100");

    // 6: asynchronous reset in the middle of a request, ack during BOOT ignored
    ack_delay = 3;
    @(negedge clk);
    check("pre_rst_req", 32'(ifa.imem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(ifa.imem_req), 32'h0);
    check("arst_valid", 32'(instr_valid_a), 32'h0);
    check("arst_instr", instr_a, NOP);
    check("arst_addr", ifa.imem_addr, 32'h0);
    @(negedge clk);
    #1;
    boot_ack  = 1'b1;
    ack_delay = 1;
    push_fetch(32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    check("boot_req", 32'(ifa.imem_req), 32'h0);
    @(negedge clk);
    check("post_boot_req", 32'(ifa.imem_req), 32'h1);
    check("post_boot_addr", ifa.imem_addr, 32'h0);
    check("boot_ack_ignored", 32'(instr_valid_a), 32'h0);
    wait_valid_a("fetch0_after_rst");
    stall_a = 1'b1;

    // 5: PC wraps from 0xFFFF_FFFC to 0
    @(negedge clk);
    rst_b = 1'b1;
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!instr_valid_b && k < 20);
    end
    check("wrap_valid", 32'(instr_valid_b), 32'h1);
    check("wrap_instr", instr_b, 32'h00A0_0113);
    check("wrap_instr_pc", instr_pc_b, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4_b, 32'h0);
    stall_b = 1'b0;
    @(negedge clk);
    stall_b = 1'b1;
    check("wrap_req", 32'(ifb.imem_req), 32'h1);
    check("wrap_addr", ifb.imem_addr, 32'h0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    check("addr_q_empty", 32'(addr_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
